// File: rtl/regfile_hazard_scoreboard_if.sv
// D-stage hazard interface: the decode stage presents its operands and
// destination, the scoreboard answers with stall and forwarding selects.
interface regfile_hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int TW = 2,
  parameter int FW = 2
);
  logic          dValid;
  logic [AW-1:0] dRs;
  logic [AW-1:0] dRt;
  logic [TW-1:0] dTuseRs;
  logic [TW-1:0] dTuseRt;
  logic [AW-1:0] dWa;
  logic [TW-1:0] dTnew;
  logic          dMdStart;
  logic          dMdDiv;
  logic          dMdUse;
  logic          flush;
  logic          stall;
  logic [FW-1:0] fwdSelRs;
  logic [FW-1:0] fwdSelRt;
  logic          mdBusy;

  modport master (
    output dValid, dRs, dRt, dTuseRs, dTuseRt, dWa, dTnew,
    output dMdStart, dMdDiv, dMdUse, flush,
    input  stall, fwdSelRs, fwdSelRt, mdBusy
  );

  modport slave (
    input  dValid, dRs, dRt, dTuseRs, dTuseRt, dWa, dTnew,
    input  dMdStart, dMdDiv, dMdUse, flush,
    output stall, fwdSelRs, fwdSelRt, mdBusy
  );
endinterface

// File: rtl/regfile_hazard_scoreboard.sv
// Hazard/forwarding scoreboard for the five-stage MIPS pipeline.
// One entry per post-decode stage (1 = E ... STAGES = W) records the
// destination register and remaining Tnew; the D-stage stall and the
// per-operand forwarding selects are derived from that state. A separate
// countdown tracks how long HI/LO stay busy after mult/div issue.
module regfile_hazard_scoreboard #(
  parameter int STAGES  = 3,
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10,
  parameter int FW      = $clog2(STAGES + 1)
) (
  input logic                     clk,
  input logic                     rst_n,
  regfile_hazard_scoreboard_if.slave bus_io
);

  localparam int MAX_CYC = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
  localparam int CW_MIN  = $clog2(MAX_CYC + 1);
  localparam int CW      = (CW_MIN < 4) ? 4 : CW_MIN;

  logic          validQ [1:STAGES];
  logic [AW-1:0] waQ    [1:STAGES];
  logic [TW-1:0] tnewQ  [1:STAGES];
  logic          validD [1:STAGES];
  logic [AW-1:0] waD    [1:STAGES];
  logic [TW-1:0] tnewD  [1:STAGES];
  logic [CW-1:0] mdCntQ;
  logic [CW-1:0] mdCntD;

  logic          rsHit;
  logic          rtHit;
  logic [FW-1:0] rsK;
  logic [FW-1:0] rtK;
  logic [TW-1:0] rsTnew;
  logic [TW-1:0] rtTnew;
  logic          rsStall;
  logic          rtStall;
  logic          mdBusy;
  logic          stall;
  logic          accept;
  logic          mdAccept;

  // Find the youngest in-flight writer of each source operand; scanning from
  // the oldest stage down lets the youngest match overwrite older ones.
  always_comb begin
    rsHit  = 1'b0;
    rsK    = '0;
    rsTnew = '0;
    rtHit  = 1'b0;
    rtK    = '0;
    rtTnew = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (validQ[k] && (waQ[k] == bus_io.dRs) && (bus_io.dRs != '0)) begin
        rsHit  = 1'b1;
        rsK    = FW'(k);
        rsTnew = tnewQ[k];
      end
      if (validQ[k] && (waQ[k] == bus_io.dRt) && (bus_io.dRt != '0)) begin
        rtHit  = 1'b1;
        rtK    = FW'(k);
        rtTnew = tnewQ[k];
      end
    end
  end

  // An operand stalls D when its producer will not have the value in time;
  // an all-ones Tuse marks the operand as not read at all.
  always_comb begin
    rsStall = (bus_io.dTuseRs != '1) && rsHit && (rsTnew > bus_io.dTuseRs);
    rtStall = (bus_io.dTuseRt != '1) && rtHit && (rtTnew > bus_io.dTuseRt);
    mdBusy  = (mdCntQ != '0);
    stall   = bus_io.dValid && (rsStall || rtStall || (bus_io.dMdUse && mdBusy));
  end

  assign bus_io.stall    = stall;
  assign bus_io.fwdSelRs = (rsHit && (rsTnew == '0)) ? rsK : '0;
  assign bus_io.fwdSelRt = (rtHit && (rtTnew == '0)) ? rtK : '0;
  assign bus_io.mdBusy   = mdBusy;

  // Next state: entries shift one stage per cycle with Tnew counting down;
  // a stalled or flushed D stage feeds a bubble into E instead.
  always_comb begin
    accept    = !stall && !bus_io.flush;
    validD[1] = accept && bus_io.dValid && (bus_io.dWa != '0);
    waD[1]    = accept ? bus_io.dWa : '0;
    tnewD[1]  = accept ? bus_io.dTnew : '0;
    for (int k = 2; k <= STAGES; k++) begin
      validD[k] = validQ[k-1] && !bus_io.flush;
      waD[k]    = waQ[k-1];
      tnewD[k]  = (tnewQ[k-1] == '0) ? '0 : (tnewQ[k-1] - TW'(1));
    end
    mdAccept = accept && bus_io.dValid && bus_io.dMdStart;
    if (mdAccept) begin
      mdCntD = bus_io.dMdDiv ? CW'(DIV_CYC) : CW'(MUL_CYC);
    end else if (mdCntQ != '0) begin
      mdCntD = mdCntQ - CW'(1);
    end else begin
      mdCntD = mdCntQ;
    end
  end

  // State registers; reset drops every in-flight entry and the HI/LO countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= STAGES; k++) begin
        validQ[k] <= 1'b0;
        waQ[k]    <= '0;
        tnewQ[k]  <= '0;
      end
      mdCntQ <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        validQ[k] <= validD[k];
        waQ[k]    <= waD[k];
        tnewQ[k]  <= tnewD[k];
      end
      mdCntQ <= mdCntD;
    end
  end

endmodule

// File: tb/tb_regfile_hazard_scoreboard.sv
// Bench for regfile_hazard_scoreboard: per-cycle D-stage vectors with their
// expected stall/forward/busy outputs, plus mult/div, flush and reset cases.
module tb_regfile_hazard_scoreboard;

  localparam int STAGES  = 3;
  localparam int AW      = 5;
  localparam int TW      = 2;
  localparam int MUL_CYC = 5;
  localparam int DIV_CYC = 10;
  localparam int FW      = 2;

  typedef struct {
    logic          v;
    logic [AW-1:0] rs;
    logic [TW-1:0] tuseRs;
    logic [AW-1:0] rt;
    logic [TW-1:0] tuseRt;
    logic [AW-1:0] wa;
    logic [TW-1:0] tnew;
    logic          mdStart;
    logic          mdDiv;
    logic          mdUse;
    logic          flush;
    logic          eStall;
    logic [FW-1:0] eFwdRs;
    logic [FW-1:0] eFwdRt;
    logic          eBusy;
  } vec_t;

  typedef struct {
    logic          stall;
    logic [FW-1:0] fwdRs;
    logic [FW-1:0] fwdRt;
    logic          busy;
    int            tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t expQ[$];
  int   compared = 0;
  int   mismatched = 0;
  vec_t tbl[18];
  vec_t idle;

  regfile_hazard_scoreboard_if #(.AW(AW), .TW(TW), .FW(FW)) bus ();

  regfile_hazard_scoreboard #(
    .STAGES(STAGES), .AW(AW), .TW(TW),
    .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC), .FW(FW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_io(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic v, input int rs, input int tuseRs,
                                 input int rt, input int tuseRt, input int wa,
                                 input int tnew, input logic mdStart, input logic mdDiv,
                                 input logic mdUse, input logic flush, input logic eStall,
                                 input int eRs, input int eRt, input logic eBusy);
    vec_t r;
    r.v = v;
    r.rs = AW'(rs);
    r.tuseRs = TW'(tuseRs);
    r.rt = AW'(rt);
    r.tuseRt = TW'(tuseRt);
    r.wa = AW'(wa);
    r.tnew = TW'(tnew);
    r.mdStart = mdStart;
    r.mdDiv = mdDiv;
    r.mdUse = mdUse;
    r.flush = flush;
    r.eStall = eStall;
    r.eFwdRs = FW'(eRs);
    r.eFwdRt = FW'(eRt);
    r.eBusy = eBusy;
    return r;
  endfunction

  task automatic expectOnly(input logic s, input int rsSel, input int rtSel,
                            input logic b, input int tag);
    exp_t e;
    e.stall = s;
    e.fwdRs = FW'(rsSel);
    e.fwdRt = FW'(rtSel);
    e.busy = b;
    e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t x, input int tag);
    bus.dValid = x.v;
    bus.dRs = x.rs;
    bus.dTuseRs = x.tuseRs;
    bus.dRt = x.rt;
    bus.dTuseRt = x.tuseRt;
    bus.dWa = x.wa;
    bus.dTnew = x.tnew;
    bus.dMdStart = x.mdStart;
    bus.dMdDiv = x.mdDiv;
    bus.dMdUse = x.mdUse;
    bus.flush = x.flush;
    expectOnly(x.eStall, int'(x.eFwdRs), int'(x.eFwdRt), x.eBusy, tag);
  endtask

  task automatic cmpField(input string name, input int tag,
                          input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s tag=%0d actual=%0d required=%0d", name, tag, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL queue-empty actual=0 required=1");
    end else begin
      e = expQ.pop_front();
      cmpField("stall", e.tag, 8'(bus.stall), 8'(e.stall));
      cmpField("fwdSelRs", e.tag, 8'(bus.fwdSelRs), 8'(e.fwdRs));
      cmpField("fwdSelRt", e.tag, 8'(bus.fwdSelRt), 8'(e.fwdRt));
      cmpField("mdBusy", e.tag, 8'(bus.mdBusy), 8'(e.busy));
    end
  endtask

  task automatic runVec(input vec_t x, input int tag);
    applyStimulus(x, tag);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Main sequence: reset, table vectors, then the multi-cycle corner cases.
  initial begin
    idle = mkVec(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //             v  rs tu rt tu wa tn mS mD mU fl   eSt eRs eRt eBusy
    tbl[0]  = mkVec(1, 2, 1, 0, 3, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mkVec(1, 1, 1, 3, 1, 2, 1, 0, 0, 0, 0,  1, 0, 0, 0);
    tbl[2]  = mkVec(1, 1, 1, 3, 1, 2, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[3]  = mkVec(1, 1, 1, 2, 1, 4, 1, 0, 0, 0, 0,  0, 3, 0, 0);
    tbl[4]  = mkVec(1, 2, 0, 4, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0);
    tbl[5]  = mkVec(1, 2, 0, 4, 0, 0, 0, 0, 0, 0, 0,  0, 3, 2, 0);
    tbl[6]  = mkVec(1, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[7]  = mkVec(1, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[8]  = mkVec(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    tbl[9]  = mkVec(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 2, 2, 0);
    tbl[10] = mkVec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0);
    tbl[11] = mkVec(1, 0, 1, 0, 1, 0, 2, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[12] = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[13] = mkVec(1, 0, 3, 0, 3, 6, 2, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[14] = mkVec(1, 6, 3, 6, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[15] = mkVec(1, 6, 0, 0, 3, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    tbl[16] = mkVec(1, 6, 0, 0, 3, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0);
    tbl[17] = idle;

    rst_n = 1'b0;
    applyStimulus(idle, 0);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      runVec(tbl[i], i + 1);
    end

    // div then mfhi: ten stalled cycles; mult: five busy cycles.
    runVec(mkVec(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0), 100);
    for (int i = 0; i < DIV_CYC; i++) begin
      runVec(mkVec(1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1), 101 + i);
    end
    runVec(mkVec(1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 120);
    runVec(mkVec(1, 0, 3, 0, 3, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), 121);
    runVec(mkVec(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 122);
    for (int i = 0; i < MUL_CYC - 1; i++) begin
      runVec(mkVec(1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1), 123 + i);
    end
    runVec(mkVec(1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 130);

    // Three producers in flight, then a flush that also rejects a mult start.
    runVec(mkVec(1, 0, 3, 0, 3, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0), 200);
    runVec(mkVec(1, 0, 3, 0, 3, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0), 201);
    runVec(mkVec(1, 7, 1, 0, 3, 9, 1, 0, 0, 0, 0, 0, 2, 0, 0), 202);
    runVec(mkVec(1, 8, 0, 9, 3, 0, 0, 1, 0, 1, 1, 0, 2, 0, 0), 203);
    runVec(mkVec(1, 8, 0, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 204);
    runVec(mkVec(1, 7, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 205);

    // div in flight with producers; async reset lands between clock edges.
    runVec(mkVec(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0), 300);
    runVec(mkVec(1, 0, 3, 0, 3, 10, 2, 0, 0, 0, 0, 0, 0, 0, 1), 301);
    runVec(mkVec(1, 0, 3, 0, 3, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1), 302);
    runVec(mkVec(1, 11, 0, 0, 3, 12, 1, 0, 0, 0, 0, 0, 1, 0, 1), 303);
    applyStimulus(mkVec(1, 11, 0, 10, 0, 0, 0, 0, 0, 1, 0, 1, 2, 3, 1), 304);
    @(negedge clk);
    checkOutput();
    #2;
    rst_n = 1'b0;
    expectOnly(0, 0, 0, 0, 305);
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    expectOnly(0, 0, 0, 0, 306);
    checkOutput();
    rst_n = 1'b1;
    expectOnly(0, 0, 0, 0, 307);
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    runVec(mkVec(1, 11, 0, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 308);
    runVec(mkVec(1, 0, 3, 0, 3, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0), 309);
    runVec(mkVec(1, 13, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 310);
    runVec(idle, 311);

    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL queue-leftover actual=%0d required=0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
